// File: rtl/cpu_seq_if.sv
// Instruction/data memory handshake bundle between the sequencer and memories.
interface cpu_seq_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic            imem_ack;
  logic [XLEN-1:0] inst;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, inst, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, inst, dmem_ack
  );
endinterface

// File: rtl/cpu_seq.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
module cpu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  cpu_seq_if.master        bus,
  input  logic             br_taken,
  output logic [XLEN-1:0]  ir,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [3:0]       alu_op,
  output logic             cmp_en,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t cur, nxt;

  logic [6:0] opc;
  logic [2:0] funct3;
  logic       rd_nz;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic       is_load, is_store, is_opimm, is_op, legal;
  logic       shift_imm;
  logic       ir_load, retire;

  assign opc    = ir[6:0];
  assign funct3 = ir[14:12];
  assign rd_nz  = (ir[11:7] != 5'd0);

  assign is_lui    = (opc == OPC_LUI);
  assign is_auipc  = (opc == OPC_AUIPC);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_branch = (opc == OPC_BRANCH);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_opimm  = (opc == OPC_OPIMM);
  assign is_op     = (opc == OPC_OP);
  assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                     is_load | is_store | is_opimm | is_op;

  // For OP-IMM, ir[30] belongs to the immediate except on the shift encodings.
  assign shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign state = cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= S_FETCH;
      ir      <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (ir_load)
        ir <= bus.inst;
      if (cur == S_DECODE && !legal)
        illegal <= 1'b1;
      if (retire)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    nxt          = cur;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_op       = 4'd0;
    cmp_en       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    ir_load      = 1'b0;
    retire       = 1'b0;

    case (cur)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_load = 1'b1;
          nxt     = S_DECODE;
        end
      end

      S_DECODE: nxt = legal ? S_EXEC : S_TRAP;

      S_EXEC: begin
        if (is_op) begin
          alu_op = {ir[30], funct3};
        end else if (is_opimm) begin
          alu_op    = {shift_imm & ir[30], funct3};
          alu_b_sel = 1'b1;
        end else if (is_auipc || is_jal) begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
        end else if (is_branch) begin
          cmp_en = 1'b1;
          alu_op = {1'b0, funct3};
        end else begin
          alu_b_sel = 1'b1;
        end

        if (is_branch) begin
          // Branches resolve here and never visit WB.
          pc_we  = 1'b1;
          pc_sel = br_taken ? 2'd1 : 2'd0;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else if (is_load || is_store) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end

      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_store;
        if (bus.dmem_ack) begin
          if (is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we  = rd_nz;
        wb_sel = is_lui ? 2'd3 : (is_jal || is_jalr) ? 2'd2 : is_load ? 2'd1 : 2'd0;
        pc_we  = 1'b1;
        pc_sel = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        retire = 1'b1;
        nxt    = S_FETCH;
      end

      S_TRAP: nxt = S_TRAP;

      default: nxt = S_FETCH;
    endcase

    // Reset silences every request and strobe immediately, even mid-handshake.
    if (!rst) begin
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      alu_op       = 4'd0;
      cmp_en       = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      rf_we        = 1'b0;
      wb_sel       = 2'd0;
      ir_load      = 1'b0;
      retire       = 1'b0;
    end
  end

endmodule
